stage1_hazard_ctrl: RTL and testbench



---
 rtl/stage1_hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_stage1_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stage1_hazard_ctrl.sv
// rtl/stage1_hazard_ctrl.sv - decode-stage stall/squash/forward controller; DECODE_FWD_EN enables operand forwarding
module stage1_hazard_ctrl (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_inst_1,
   input  logic        i_valid_1,
   input  logic        i_mem_stall,
   input  logic        i_br_taken_2,
   output logic        o_stall_1,
   output logic        o_kill_1,
   output logic        o_valid_2,
   output logic        o_valid_3,
   output logic [1:0]  o_fwd_rs1_sel,
   output logic [1:0]  o_fwd_rs2_sel,
   output logic [31:0] o_stall_cnt,
   output logic [31:0] o_kill_cnt
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic {ST_RUN, ST_KILL} state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_s2_v, r_s2_wr, r_s2_ld;
   logic [4:0]  r_s2_rd;
   logic        r_s3_v, r_s3_wr;
   logic [4:0]  r_s3_rd;
   logic [31:0] r_stall_cnt, r_kill_cnt;

   logic [6:0]  w_opcode;
   logic [4:0]  w_rd, w_rs1, w_rs2;
   logic        w_use_rs1, w_use_rs2, w_wr, w_ld;
   logic        w_s2_rs1, w_s2_rs2, w_s3_rs1, w_s3_rs2;
   logic        w_hazard, w_kill, w_bubble;
   logic [1:0]  w_fwd1, w_fwd2;
   logic        w_unused;

   assign w_opcode = i_inst_1[6:0];
   assign w_rd     = i_inst_1[11:7];
   assign w_rs1    = i_inst_1[19:15];
   assign w_rs2    = i_inst_1[24:20];
   assign w_unused = ^{i_inst_1[31:25], i_inst_1[13:12], r_s2_ld};

   // Operand usage and destination class of the stage1 instruction
   always_comb begin
      w_use_rs1 = 1'b1;
      w_use_rs2 = 1'b0;
      w_wr      = 1'b1;
      w_ld      = 1'b0;
      case (w_opcode)
         OPC_LUI, OPC_AUIPC, OPC_JAL: w_use_rs1 = 1'b0;
         OPC_SYSTEM:                  w_use_rs1 = ~i_inst_1[14];
         OPC_OP:                      w_use_rs2 = 1'b1;
         OPC_STORE, OPC_BRANCH: begin
            w_use_rs2 = 1'b1;
            w_wr      = 1'b0;
         end
         OPC_LOAD:                    w_ld = 1'b1;
         default: ;
      endcase
   end

   // A source matches a slot only if the slot really writes a non-x0 register
   assign w_s2_rs1 = w_use_rs1 && (w_rs1 != 5'd0) && r_s2_v && r_s2_wr && (r_s2_rd == w_rs1);
   assign w_s2_rs2 = w_use_rs2 && (w_rs2 != 5'd0) && r_s2_v && r_s2_wr && (r_s2_rd == w_rs2);
   assign w_s3_rs1 = w_use_rs1 && (w_rs1 != 5'd0) && r_s3_v && r_s3_wr && (r_s3_rd == w_rs1);
   assign w_s3_rs2 = w_use_rs2 && (w_rs2 != 5'd0) && r_s3_v && r_s3_wr && (r_s3_rd == w_rs2);

`ifdef DECODE_FWD_EN
   // Only a load in stage2 cannot be bypassed; everything else forwards
   assign w_hazard = (w_s2_rs1 | w_s2_rs2) & r_s2_ld;

   // Forward select: youngest producer (stage2) wins over stage3
   always_comb begin
      w_fwd1 = 2'b00;
      w_fwd2 = 2'b00;
      if (i_valid_1 && !i_reset) begin
         if (w_s2_rs1 && !r_s2_ld) w_fwd1 = 2'b01;
         else if (w_s3_rs1)        w_fwd1 = 2'b10;
         if (w_s2_rs2 && !r_s2_ld) w_fwd2 = 2'b01;
         else if (w_s3_rs2)        w_fwd2 = 2'b10;
      end
   end
`else
   // No bypass network: any in-flight producer blocks the consumer
   assign w_hazard = w_s2_rs1 | w_s2_rs2 | w_s3_rs1 | w_s3_rs2;
   assign w_fwd1   = 2'b00;
   assign w_fwd2   = 2'b00;
`endif

   // Redirect FSM: squash the current slot on redirect and the wrong-path fetch after it
   always_comb begin
      w_state_nxt = r_state;
      w_kill      = 1'b0;
      case (r_state)
         ST_RUN: begin
            w_kill = i_br_taken_2;
            if (i_br_taken_2 && !i_mem_stall) w_state_nxt = ST_KILL;
         end
         ST_KILL: begin
            w_kill = 1'b1;
            if (!i_mem_stall) w_state_nxt = ST_RUN;
         end
      endcase
      if (i_reset) w_kill = 1'b1;
   end

   assign o_kill_1      = w_kill;
   assign o_stall_1     = i_valid_1 & ~w_kill & w_hazard;
   assign o_fwd_rs1_sel = w_fwd1;
   assign o_fwd_rs2_sel = w_fwd2;
   assign o_valid_2     = r_s2_v;
   assign o_valid_3     = r_s3_v;
   assign o_stall_cnt   = r_stall_cnt;
   assign o_kill_cnt    = r_kill_cnt;
   assign w_bubble      = o_stall_1 | w_kill | ~i_valid_1;

   // Redirect state register
   always_ff @(posedge i_clk) begin
      if (i_reset) r_state <= ST_RUN;
      else         r_state <= w_state_nxt;
   end

   // Shadow pipeline of destination metadata, frozen by the memory system
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_s2_v  <= 1'b0;
         r_s2_wr <= 1'b0;
         r_s2_ld <= 1'b0;
         r_s2_rd <= 5'd0;
         r_s3_v  <= 1'b0;
         r_s3_wr <= 1'b0;
         r_s3_rd <= 5'd0;
      end else if (!i_mem_stall) begin
         r_s3_v  <= r_s2_v;
         r_s3_wr <= r_s2_wr;
         r_s3_rd <= r_s2_rd;
         r_s2_v  <= ~w_bubble;
         r_s2_wr <= ~w_bubble & w_wr;
         r_s2_ld <= ~w_bubble & w_ld;
         r_s2_rd <= w_bubble ? 5'd0 : w_rd;
      end
   end

   // Hazard cycle counters for performance debug (free-running wrap)
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_stall_cnt <= 32'd0;
         r_kill_cnt  <= 32'd0;
      end else if (!i_mem_stall) begin
         r_stall_cnt <= r_stall_cnt + {31'd0, o_stall_1 & ~w_kill};
         r_kill_cnt  <= r_kill_cnt + {31'd0, w_kill};
      end
   end

endmodule

// File: tb/tb_stage1_hazard_ctrl.sv
// tb/tb_stage1_hazard_ctrl.sv - self-checking bench for stage1_hazard_ctrl with behavioural model
module tb_stage1_hazard_ctrl;

   localparam logic [31:0] I_ADDI5 = 32'h00100293;
   localparam logic [31:0] I_ADD6  = 32'h00528333;
   localparam logic [31:0] I_ADD8  = 32'h00038433;
   localparam logic [31:0] I_ADD9  = 32'h000284B3;
   localparam logic [31:0] I_LW7   = 32'h0000A383;
   localparam logic [31:0] I_ADD0  = 32'h00000033;
   localparam logic [31:0] I_ADD1  = 32'h000000B3;
   localparam logic [31:0] I_NOP   = 32'h00000013;

   logic        i_clk = 1'b0;
   logic        i_reset, i_valid_1, i_mem_stall, i_br_taken_2;
   logic [31:0] i_inst_1;
   logic        o_stall_1, o_kill_1, o_valid_2, o_valid_3;
   logic [1:0]  o_fwd_rs1_sel, o_fwd_rs2_sel;
   logic [31:0] o_stall_cnt, o_kill_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   stage1_hazard_ctrl dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_inst_1(i_inst_1), .i_valid_1(i_valid_1),
      .i_mem_stall(i_mem_stall), .i_br_taken_2(i_br_taken_2),
      .o_stall_1(o_stall_1), .o_kill_1(o_kill_1), .o_valid_2(o_valid_2), .o_valid_3(o_valid_3),
      .o_fwd_rs1_sel(o_fwd_rs1_sel), .o_fwd_rs2_sel(o_fwd_rs2_sel),
      .o_stall_cnt(o_stall_cnt), .o_kill_cnt(o_kill_cnt)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      bit       u1, u2, wr, ld;
      bit [4:0] rs1, rs2, rd;
   } dec_t;

   typedef struct {
      bit       v, wr, ld;
      bit [4:0] rd;
   } slot_t;

   slot_t     m_s2 = '{default: 0};
   slot_t     m_s3 = '{default: 0};
   bit        m_kill_left = 0;
   bit [31:0] m_scnt = 0;
   bit [31:0] m_kcnt = 0;

   function automatic dec_t decode(input logic [31:0] ins);
      dec_t d;
      bit [6:0] op;
      op    = ins[6:0];
      d.rs1 = ins[19:15];
      d.rs2 = ins[24:20];
      d.rd  = ins[11:7];
      d.u1  = !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
      if (op == 7'b1110011) d.u1 = (ins[14] == 1'b0);
      d.u2  = (op inside {7'b0110011, 7'b0100011, 7'b1100011});
      d.wr  = !(op inside {7'b0100011, 7'b1100011});
      d.ld  = (op == 7'b0000011);
      return d;
   endfunction

   function automatic bit hits(input slot_t s, input bit used, input bit [4:0] rs);
      return used && rs != 0 && s.v && s.wr && s.rd == rs;
   endfunction

   function automatic bit [1:0] fsel(input bit used, input bit [4:0] rs);
`ifdef DECODE_FWD_EN
      if (hits(m_s2, used, rs) && !m_s2.ld) return 2'b01;
      if (hits(m_s3, used, rs))             return 2'b10;
`endif
      return 2'b00;
   endfunction

   // Compare on the falling edge, then advance the model to the coming rising edge
   always @(negedge i_clk) begin
      dec_t     d;
      bit       kill, stall, raw;
      bit [1:0] f1, f2;
      d    = decode(i_inst_1);
      kill = i_reset || m_kill_left || i_br_taken_2;
`ifdef DECODE_FWD_EN
      raw  = m_s2.ld && (hits(m_s2, d.u1, d.rs1) || hits(m_s2, d.u2, d.rs2));
`else
      raw  = hits(m_s2, d.u1, d.rs1) || hits(m_s2, d.u2, d.rs2) ||
             hits(m_s3, d.u1, d.rs1) || hits(m_s3, d.u2, d.rs2);
`endif
      stall = i_valid_1 && !kill && raw;
      f1 = (i_valid_1 && !i_reset) ? fsel(d.u1, d.rs1) : 2'b00;
      f2 = (i_valid_1 && !i_reset) ? fsel(d.u2, d.rs2) : 2'b00;

      chk("m_kill",  o_kill_1,      kill);
      chk("m_stall", o_stall_1,     stall);
      chk("m_fwd1",  o_fwd_rs1_sel, f1);
      chk("m_fwd2",  o_fwd_rs2_sel, f2);
      chk("m_v2",    o_valid_2,     m_s2.v);
      chk("m_v3",    o_valid_3,     m_s3.v);
      chk("m_scnt",  o_stall_cnt,   m_scnt);
      chk("m_kcnt",  o_kill_cnt,    m_kcnt);

      if (i_reset) begin
         m_s2 = '{default: 0};
         m_s3 = '{default: 0};
         m_kill_left = 0;
         m_scnt = 0;
         m_kcnt = 0;
      end else if (!i_mem_stall) begin
         m_s3 = m_s2;
         if (stall || kill || !i_valid_1) m_s2 = '{default: 0};
         else m_s2 = '{v: 1, wr: d.wr, ld: d.ld, rd: d.rd};
         if (stall) m_scnt++;
         if (kill)  m_kcnt++;
         m_kill_left = !m_kill_left && i_br_taken_2;
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic [31:0] ins, input logic v, input logic ms,
                        input logic br, input logic rst);
      @(posedge i_clk);
      #1;
      i_inst_1 = ins; i_valid_1 = v; i_mem_stall = ms; i_br_taken_2 = br; i_reset = rst;
      @(negedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      drive(I_ADD6, 1, 0, 0, 1);
      drive(I_ADD6, 1, 0, 0, 1);
   endtask

   function automatic logic [31:0] rand_inst();
      logic [6:0] ops [10];
      logic [6:0] op;
      ops = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};
      op = ops[$urandom_range(0, 9)];
      return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              3'($urandom), 5'($urandom_range(0, 3)), op};
   endfunction

   initial begin
      i_reset = 1; i_inst_1 = I_ADD6; i_valid_1 = 1; i_mem_stall = 0; i_br_taken_2 = 0;

      // Reset behaviour
      drive(I_ADD6, 1, 0, 0, 1);
      chk("rst_kill", o_kill_1, 1); chk("rst_stall", o_stall_1, 0);
      chk("rst_fwd1", o_fwd_rs1_sel, 0); chk("rst_fwd2", o_fwd_rs2_sel, 0);
      drive(I_ADD6, 1, 0, 0, 1);
      chk("rst_scnt", o_stall_cnt, 0); chk("rst_kcnt", o_kill_cnt, 0);
      drive(I_NOP, 1, 0, 0, 0);
      chk("post_v2", o_valid_2, 0); chk("post_v3", o_valid_3, 0);
      chk("post_stall", o_stall_1, 0); chk("post_kill", o_kill_1, 0);

      // ALU RAW
      do_reset();
      drive(I_ADDI5, 1, 0, 0, 0); chk("alu_c1_stall", o_stall_1, 0);
      drive(I_ADD6, 1, 0, 0, 0);
`ifdef DECODE_FWD_EN
      chk("alu_fwd1", o_fwd_rs1_sel, 1); chk("alu_fwd2", o_fwd_rs2_sel, 1);
      chk("alu_stall", o_stall_1, 0);
      drive(I_ADD9, 1, 0, 0, 0);
      chk("alu_s3_fwd1", o_fwd_rs1_sel, 2); chk("alu_s3_fwd2", o_fwd_rs2_sel, 0);
      drive(I_ADD8, 1, 0, 0, 0); chk("alu_scnt", o_stall_cnt, 0);
`else
      chk("alu_stall_a", o_stall_1, 1); chk("alu_fwd1", o_fwd_rs1_sel, 0);
      drive(I_ADD6, 1, 0, 0, 0); chk("alu_stall_b", o_stall_1, 1);
      drive(I_ADD6, 1, 0, 0, 0); chk("alu_stall_c", o_stall_1, 0);
      chk("alu_scnt", o_stall_cnt, 2);
`endif

      // Load-use
      do_reset();
      drive(I_LW7, 1, 0, 0, 0);  chk("lu_c1_stall", o_stall_1, 0);
      drive(I_ADD8, 1, 0, 0, 0); chk("lu_stall", o_stall_1, 1);
      drive(I_ADD8, 1, 0, 0, 0); chk("lu_v2", o_valid_2, 0);
`ifdef DECODE_FWD_EN
      chk("lu_after_stall", o_stall_1, 0); chk("lu_fwd1", o_fwd_rs1_sel, 2);
      drive(I_NOP, 1, 0, 0, 0); chk("lu_scnt", o_stall_cnt, 1);
`else
      chk("lu_stall2", o_stall_1, 1);
      drive(I_ADD8, 1, 0, 0, 0); chk("lu_after_stall", o_stall_1, 0);
      chk("lu_scnt", o_stall_cnt, 2);
`endif

      // Branch redirect over a pending load-use
      do_reset();
      drive(I_LW7, 1, 0, 0, 0);
      drive(I_ADD8, 1, 0, 1, 0);
      chk("br_kill_a", o_kill_1, 1); chk("br_stall_a", o_stall_1, 0);
      drive(I_NOP, 1, 0, 0, 0);
      chk("br_kill_b", o_kill_1, 1); chk("br_stall_b", o_stall_1, 0); chk("br_v2_a", o_valid_2, 0);
      drive(I_NOP, 1, 0, 0, 0);
      chk("br_kill_c", o_kill_1, 0); chk("br_v2_b", o_valid_2, 0); chk("br_kcnt", o_kill_cnt, 2);

      // Memory freeze during a load-use stall
      do_reset();
      drive(I_LW7, 1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(I_ADD8, 1, 1, 0, 0);
         chk("frz_stall", o_stall_1, 1); chk("frz_v2", o_valid_2, 1); chk("frz_scnt", o_stall_cnt, 0);
      end
      drive(I_ADD8, 1, 0, 0, 0); chk("frz_rel_stall", o_stall_1, 1);
      drive(I_ADD8, 1, 0, 0, 0);
`ifdef DECODE_FWD_EN
      chk("frz_done", o_stall_1, 0); chk("frz_scnt_end", o_stall_cnt, 1);
`else
      chk("frz_done", o_stall_1, 1); chk("frz_scnt_mid", o_stall_cnt, 1);
      drive(I_ADD8, 1, 0, 0, 0); chk("frz_scnt_end", o_stall_cnt, 2);
`endif

      // x0 never hazards
      do_reset();
      drive(I_ADD0, 1, 0, 0, 0);
      drive(I_ADD1, 1, 0, 0, 0);
      chk("x0_stall", o_stall_1, 0); chk("x0_fwd1", o_fwd_rs1_sel, 0); chk("x0_fwd2", o_fwd_rs2_sel, 0);

      // Reset mid-KILL leaves no residual squash
      drive(I_NOP, 1, 0, 1, 0);
      drive(I_NOP, 1, 0, 0, 1);
      drive(I_NOP, 1, 0, 0, 0);
      chk("rstkill_kill", o_kill_1, 0); chk("rstkill_kcnt", o_kill_cnt, 0);

      // Randomised traffic against the model
      for (int i = 0; i < 4000; i++) begin
         drive(rand_inst(), ($urandom_range(0, 7) != 0), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 7) == 0), ($urandom_range(0, 199) == 0));
      end

      @(posedge i_clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
